// File: rtl/sprite_layer_compositor_pkg.sv
// Shared widths, layer ids and colour helpers for the sprite layer compositor.
package compositor_pkg;

    localparam int COORD_W = 10;
    localparam int LAYER_W = 4;
    localparam logic [LAYER_W-1:0] LAYER_BG = 4'd15;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

    function automatic logic [7:0] expand4to8(input logic [3:0] v);
        return {v, v};
    endfunction

endpackage

// File: rtl/sprite_hit_addr.sv
// Per-layer hit test and sprite ROM address from the shadowed top-left position.
module sprite_hit_addr
    import compositor_pkg::*;
#(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int ADDR_W   = 10
) (
    input  logic [COORD_W-1:0] draw_x_i,
    input  logic [COORD_W-1:0] draw_y_i,
    input  logic [COORD_W-1:0] sx_i,
    input  logic [COORD_W-1:0] sy_i,
    input  logic               en_i,
    output logic               hit_o,
    output logic [ADDR_W-1:0]  addr_o
);

    localparam int XW = $clog2(SPRITE_W);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;

    // Offsets wrap modulo 1024, so pixels left of / above the sprite never hit.
    assign dx = draw_x_i - sx_i;
    assign dy = draw_y_i - sy_i;

    assign hit_o  = en_i && (dx < COORD_W'(SPRITE_W)) && (dy < COORD_W'(SPRITE_H));
    assign addr_o = hit_o ? ADDR_W'({dy, dx[XW-1:0]}) : '0;

endmodule

// File: rtl/sprite_layer_compositor.sv
// Composites a background layer and NUM_SPRITES prioritised sprite layers into
// registered 8-bit RGB, with per-frame shadowed positions and collision reporting.
module sprite_layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_SPRITES     = 4,
    parameter int SPRITE_W        = 32,
    parameter int SPRITE_H        = 32,
    parameter int SCREEN_W        = 640,
    parameter int IDX_W           = 4,
    parameter int ROM_LAT         = 1,
    parameter int TRANSPARENT_IDX = 0,
    localparam int ADDR_W         = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic                             vga_clk,
    input  logic                             reset_n,
    input  logic [COORD_W-1:0]               DrawX,
    input  logic [COORD_W-1:0]               DrawY,
    input  logic                             blank,
    input  logic                             frame_start,
    input  logic [NUM_SPRITES*COORD_W-1:0]   SpriteX,
    input  logic [NUM_SPRITES*COORD_W-1:0]   SpriteY,
    input  logic [NUM_SPRITES-1:0]           sprite_en,
    output logic [NUM_SPRITES*ADDR_W-1:0]    sprite_rom_addr,
    input  logic [NUM_SPRITES*IDX_W-1:0]     sprite_rom_q,
    output logic [18:0]                      bg_rom_addr,
    input  logic [IDX_W-1:0]                 bg_rom_q,
    output logic [LAYER_W-1:0]               pal_layer,
    output logic [IDX_W-1:0]                 pal_index,
    input  logic [3:0]                       pal_red,
    input  logic [3:0]                       pal_green,
    input  logic [3:0]                       pal_blue,
    output logic [7:0]                       Red,
    output logic [7:0]                       Green,
    output logic [7:0]                       Blue,
    output logic [NUM_SPRITES-1:0]           collision
);

    logic [NUM_SPRITES*COORD_W-1:0] sx_q, sx_d;
    logic [NUM_SPRITES*COORD_W-1:0] sy_q, sy_d;
    logic [NUM_SPRITES-1:0]         en_q, en_d;
    logic [NUM_SPRITES-1:0]         acc_q, acc_d;
    logic [NUM_SPRITES-1:0]         collision_q, collision_d;

    logic [NUM_SPRITES-1:0]         hit_c;
    logic [NUM_SPRITES-1:0]         hit_pipe_q [ROM_LAT];
    logic [ROM_LAT-1:0]             blank_pipe_q;
    logic [NUM_SPRITES-1:0]         hit_al;
    logic                           blank_al;

    logic [NUM_SPRITES-1:0]         opaque_c;
    logic [NUM_SPRITES-1:0]         pair_c;
    logic [NUM_SPRITES-1:0]         coll_c;

    logic [LAYER_W-1:0]             pal_layer_q, pal_layer_d;
    logic [IDX_W-1:0]               pal_index_q, pal_index_d;
    logic                           blank_s1_q;
    logic [7:0]                     red_q, red_d;
    logic [7:0]                     green_q, green_d;
    logic [7:0]                     blue_q, blue_d;
    rgb4_t                          pal_c;

    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_layer
        sprite_hit_addr #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H),
            .ADDR_W   (ADDR_W)
        ) u_hit (
            .draw_x_i (DrawX),
            .draw_y_i (DrawY),
            .sx_i     (sx_q[gi*COORD_W +: COORD_W]),
            .sy_i     (sy_q[gi*COORD_W +: COORD_W]),
            .en_i     (en_q[gi]),
            .hit_o    (hit_c[gi]),
            .addr_o   (sprite_rom_addr[gi*ADDR_W +: ADDR_W])
        );
    end

    assign bg_rom_addr = 19'(DrawX) + 19'(DrawY) * 19'(SCREEN_W);

    assign hit_al   = hit_pipe_q[ROM_LAT-1];
    assign blank_al = blank_pipe_q[ROM_LAT-1];
    assign pal_c    = '{r: pal_red, g: pal_green, b: pal_blue};

    always_comb begin
        opaque_c    = '0;
        pair_c      = '0;
        pal_layer_d = LAYER_BG;
        pal_index_d = bg_rom_q;

        for (int i = 0; i < NUM_SPRITES; i++) begin
            opaque_c[i] = hit_al[i] &&
                          (sprite_rom_q[i*IDX_W +: IDX_W] != IDX_W'(TRANSPARENT_IDX));
        end

        // Walk from the bottom layer up so the lowest opaque index wins.
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque_c[i]) begin
                pal_layer_d = LAYER_W'(i);
                pal_index_d = sprite_rom_q[i*IDX_W +: IDX_W];
            end
        end

        for (int j = 1; j < NUM_SPRITES; j++) begin
            pair_c[j] = opaque_c[0] && opaque_c[j] && blank_al;
        end
        coll_c    = pair_c;
        coll_c[0] = |pair_c;

        sx_d        = sx_q;
        sy_d        = sy_q;
        en_d        = en_q;
        collision_d = collision_q;
        acc_d       = acc_q | coll_c;
        // Hand-over edge: the accumulation of this cycle is dropped on purpose.
        if (frame_start) begin
            sx_d        = SpriteX;
            sy_d        = SpriteY;
            en_d        = sprite_en;
            collision_d = acc_q;
            acc_d       = '0;
        end

        red_d   = blank_s1_q ? expand4to8(pal_c.r) : 8'h00;
        green_d = blank_s1_q ? expand4to8(pal_c.g) : 8'h00;
        blue_d  = blank_s1_q ? expand4to8(pal_c.b) : 8'h00;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q         <= '0;
            sy_q         <= '0;
            en_q         <= '0;
            acc_q        <= '0;
            collision_q  <= '0;
            for (int k = 0; k < ROM_LAT; k++) hit_pipe_q[k] <= '0;
            blank_pipe_q <= '0;
            pal_layer_q  <= LAYER_BG;
            pal_index_q  <= '0;
            blank_s1_q   <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
        end else begin
            sx_q            <= sx_d;
            sy_q            <= sy_d;
            en_q            <= en_d;
            acc_q           <= acc_d;
            collision_q     <= collision_d;
            hit_pipe_q[0]   <= hit_c;
            blank_pipe_q[0] <= blank;
            for (int k = 1; k < ROM_LAT; k++) begin
                hit_pipe_q[k]   <= hit_pipe_q[k-1];
                blank_pipe_q[k] <= blank_pipe_q[k-1];
            end
            pal_layer_q     <= pal_layer_d;
            pal_index_q     <= pal_index_d;
            blank_s1_q      <= blank_al;
            red_q           <= red_d;
            green_q         <= green_d;
            blue_q          <= blue_d;
        end
    end

    assign pal_layer = pal_layer_q;
    assign pal_index = pal_index_q;
    assign Red       = red_q;
    assign Green     = green_q;
    assign Blue      = blue_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Bench for sprite_layer_compositor: directed vectors plus randomized frames
// checked against a pixel-level reference model with ROM and palette stand-ins.
module tb_sprite_layer_compositor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank, frame_start;
    logic [39:0] SpriteX, SpriteY;
    logic [3:0]  sprite_en;
    logic [39:0] sprite_rom_addr;
    logic [15:0] sprite_rom_q;
    logic [18:0] bg_rom_addr;
    logic [3:0]  bg_rom_q;
    logic [3:0]  pal_layer, pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic [7:0]  Red, Green, Blue;
    logic [3:0]  collision;

    int n_cmp = 0;
    int n_err = 0;

    bit         dir_mode;
    logic [3:0] q_const [4];

    int         m_sx [4];
    int         m_sy [4];
    bit   [3:0] m_en;
    logic [3:0] m_acc;
    logic [3:0] m_coll;
    logic [23:0] expq [$];

    typedef struct {
        int x;
        int y;
        int exp_addr;
    } vec_t;
    vec_t vt [9];

    sprite_layer_compositor dut (
        .vga_clk         (clk),
        .reset_n         (reset_n),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .blank           (blank),
        .frame_start     (frame_start),
        .SpriteX         (SpriteX),
        .SpriteY         (SpriteY),
        .sprite_en       (sprite_en),
        .sprite_rom_addr (sprite_rom_addr),
        .sprite_rom_q    (sprite_rom_q),
        .bg_rom_addr     (bg_rom_addr),
        .bg_rom_q        (bg_rom_q),
        .pal_layer       (pal_layer),
        .pal_index       (pal_index),
        .pal_red         (pal_red),
        .pal_green       (pal_green),
        .pal_blue        (pal_blue),
        .Red             (Red),
        .Green           (Green),
        .Blue            (Blue),
        .collision       (collision)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] spr_rom(input int i, input int a);
        int v;
        v = (a * 5 + i * 11 + a / 37) % 16;
        return (v < 4) ? 4'd0 : v[3:0];
    endfunction

    function automatic logic [3:0] bg_rom(input int a);
        int v;
        v = (a * 3 + a / 640) % 16;
        return v[3:0];
    endfunction

    function automatic logic [11:0] pal_fn(input logic [3:0] l, input logic [3:0] i);
        return {i ^ l, i + 4'd5, l * 4'd3 + i * 4'd7};
    endfunction

    // One-cycle ROMs and a combinational palette.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            sprite_rom_q[i*4 +: 4] <= dir_mode ? q_const[i] : spr_rom(i, int'(sprite_rom_addr[i*10 +: 10]));
        bg_rom_q <= dir_mode ? 4'd3 : bg_rom(int'(bg_rom_addr));
    end

    assign {pal_red, pal_green, pal_blue} = dir_mode ? 12'hA51 : pal_fn(pal_layer, pal_index);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input bit bl);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = bl;
    endtask

    task automatic dir_frame();
        blank       = 1'b0;
        frame_start = 1'b0;
        tick();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic model_pixel(input int x, input int y, input bit bl,
                               output logic [23:0] rgb, output logic [3:0] opq);
        logic [3:0]  lay, idx, v;
        logic [11:0] p;
        int dx, dy;
        lay = 4'd15;
        idx = bg_rom((x + y * 640) % 524288);
        opq = '0;
        for (int i = 0; i < 4; i++) begin
            dx = (x - m_sx[i] + 1024) % 1024;
            dy = (y - m_sy[i] + 1024) % 1024;
            if (m_en[i] && dx < 32 && dy < 32) begin
                v = spr_rom(i, dy * 32 + dx);
                if (v != 4'd0) begin
                    opq[i] = 1'b1;
                    if (lay == 4'd15) begin
                        lay = 4'(i);
                        idx = v;
                    end
                end
            end
        end
        p   = pal_fn(lay, idx);
        rgb = bl ? {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]} : 24'h0;
    endtask

    task automatic drive_cycle(input int x, input int y, input bit bl, input bit fs);
        logic [23:0] rgb, e;
        logic [3:0]  opq;
        @(posedge clk);
        #1;
        set_pix(x, y, bl);
        frame_start = fs;
        model_pixel(x, y, bl, rgb, opq);
        if (bl && opq[0]) begin
            for (int j = 1; j < 4; j++) begin
                if (opq[j]) begin
                    m_acc[j] = 1'b1;
                    m_acc[0] = 1'b1;
                end
            end
        end
        if (fs) begin
            m_coll = m_acc;
            m_acc  = '0;
            for (int i = 0; i < 4; i++) begin
                m_sx[i] = int'(SpriteX[i*10 +: 10]);
                m_sy[i] = int'(SpriteY[i*10 +: 10]);
            end
            m_en = sprite_en;
        end
        expq.push_back(rgb);
        @(negedge clk);
        if (expq.size() == 4) begin
            e = expq.pop_front();
            check("rand_rgb", {Red, Green, Blue}, e);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{103, 52, 67};
        vt[1] = '{132, 52, 0};
        vt[2] = '{131, 52, 95};
        vt[3] = '{100, 50, 0};
        vt[4] = '{99, 50, 0};
        vt[5] = '{100, 81, 992};
        vt[6] = '{100, 82, 0};
        vt[7] = '{131, 81, 1023};
        vt[8] = '{100, 49, 0};

        reset_n = 1'b0;
        set_pix(0, 0, 1'b0);
        frame_start = 1'b0;
        SpriteX = '0;
        SpriteY = '0;
        sprite_en = '0;
        dir_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q_const[i] = 4'd0;
            m_sx[i] = 0;
            m_sy[i] = 0;
        end
        m_en = '0;
        m_acc = '0;
        m_coll = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_rgb", {Red, Green, Blue}, 24'h0);
        check("rst_pal_layer", pal_layer, 4'd15);
        check("rst_pal_index", pal_index, 4'd0);
        check("rst_collision", collision, 4'd0);

        // Background only, latency ROM_LAT+2.
        tick();
        set_pix(10, 10, 1'b1);
        tick();
        tick();
        check("bg_layer", pal_layer, 4'd15);
        check("bg_index", pal_index, 4'd3);
        check("bg_early", {Red, Green, Blue}, 24'h0);
        tick();
        check("bg_rgb", {Red, Green, Blue}, 24'hAA5511);
        blank = 1'b0;
        repeat (3) tick();
        check("bg_blanked", {Red, Green, Blue}, 24'h0);

        // Single sprite address table.
        SpriteX[10 +: 10] = 10'd100;
        SpriteY[10 +: 10] = 10'd50;
        sprite_en = 4'b0010;
        dir_frame();
        for (int k = 0; k < 9; k++) begin
            set_pix(vt[k].x, vt[k].y, 1'b1);
            #1;
            check($sformatf("addr1_%0d_%0d", vt[k].x, vt[k].y), sprite_rom_addr[10 +: 10], vt[k].exp_addr);
        end
        set_pix(103, 52, 1'b1);
        #1;
        check("addr0_disabled", sprite_rom_addr[0 +: 10], 10'd0);
        check("bg_addr", bg_rom_addr, 19'(103 + 52 * 640));

        // Priority and transparency.
        SpriteX[0 +: 10] = 10'd200;
        SpriteY[0 +: 10] = 10'd200;
        SpriteX[20 +: 10] = 10'd200;
        SpriteY[20 +: 10] = 10'd200;
        sprite_en = 4'b0101;
        q_const[0] = 4'd0;
        q_const[2] = 4'd7;
        dir_frame();
        set_pix(205, 205, 1'b1);
        tick();
        tick();
        check("prio_transp_layer", pal_layer, 4'd2);
        check("prio_transp_index", pal_index, 4'd7);
        q_const[0] = 4'd5;
        tick();
        tick();
        check("prio_top_layer", pal_layer, 4'd0);
        check("prio_top_index", pal_index, 4'd5);

        // Double buffering of positions.
        q_const[1] = 4'd9;
        SpriteX[10 +: 10] = 10'd100;
        SpriteY[10 +: 10] = 10'd50;
        sprite_en = 4'b0010;
        dir_frame();
        set_pix(105, 60, 1'b1);
        tick();
        tick();
        check("dbuf_initial", pal_layer, 4'd1);
        SpriteX[10 +: 10] = 10'd300;
        tick();
        tick();
        check("dbuf_hold_old", pal_layer, 4'd1);
        set_pix(305, 60, 1'b1);
        tick();
        tick();
        check("dbuf_hold_new", pal_layer, 4'd15);
        dir_frame();
        set_pix(305, 60, 1'b1);
        tick();
        tick();
        check("dbuf_moved_new", pal_layer, 4'd1);
        set_pix(105, 60, 1'b1);
        tick();
        tick();
        check("dbuf_moved_old", pal_layer, 4'd15);

        // Collision between sprites 0 and 3.
        q_const[0] = 4'd5;
        q_const[3] = 4'd6;
        SpriteX[0 +: 10] = 10'd400;
        SpriteY[0 +: 10] = 10'd100;
        SpriteX[30 +: 10] = 10'd400;
        SpriteY[30 +: 10] = 10'd100;
        sprite_en = 4'b1001;
        dir_frame();
        set_pix(410, 110, 1'b1);
        tick();
        tick();
        dir_frame();
        check("coll_set", collision, 4'b1001);

        // Asynchronous reset in active video.
        set_pix(410, 110, 1'b1);
        repeat (3) tick();
        check("pre_reset_rgb", {Red, Green, Blue}, 24'hAA5511);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_red", Red, 8'h00);
        check("async_rst_coll", collision, 4'd0);
        check("async_rst_index", pal_index, 4'd0);
        check("async_rst_layer", pal_layer, 4'd15);
        @(negedge clk);
        reset_n = 1'b1;
        set_pix(410, 110, 1'b1);
        tick();
        tick();
        check("post_rst_no_sprite", pal_layer, 4'd15);

        // Collision clears after a frame with only blanked or no overlap.
        dir_frame();
        set_pix(410, 110, 1'b1);
        tick();
        tick();
        dir_frame();
        check("coll_set2", collision, 4'b1001);
        set_pix(410, 110, 1'b0);
        tick();
        tick();
        set_pix(10, 10, 1'b1);
        tick();
        tick();
        dir_frame();
        check("coll_clear", collision, 4'd0);

        // Randomized frames against the reference model.
        dir_mode = 1'b0;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) begin
                SpriteX[i*10 +: 10] = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023))
                                                                   : 10'($urandom_range(0, 90));
                SpriteY[i*10 +: 10] = 10'($urandom_range(0, 90));
            end
            sprite_en = 4'($urandom);
            repeat (4) drive_cycle(0, 0, 1'b0, 1'b0);
            drive_cycle(0, 0, 1'b0, 1'b1);
            repeat (3) drive_cycle(0, 0, 1'b0, 1'b0);
            check("rand_coll", collision, m_coll);
            for (int r = 0; r < 3; r++) begin
                int ry;
                ry = $urandom_range(0, 120);
                for (int x = 0; x < 128; x++) begin
                    if (r == 1 && x == 64)
                        SpriteX[0 +: 10] = 10'($urandom_range(0, 90));
                    drive_cycle(x, ry, $urandom_range(0, 9) != 0, 1'b0);
                end
            end
        end
        repeat (4) drive_cycle(0, 0, 1'b0, 1'b0);
        drive_cycle(0, 0, 1'b0, 1'b1);
        repeat (3) drive_cycle(0, 0, 1'b0, 1'b0);
        check("rand_coll_final", collision, m_coll);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
